// File: rtl/ui_arrow_drawer_if.sv
// Pixel-plotting handshake between an arrow request source and the drawer.
// The master issues draw requests; the slave (the drawer) returns VGA pixel writes.
interface ui_arrow_drawer_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic [1:0]          dir;
    logic                erase;
    logic [COLOUR_W-1:0] colour;
    logic [X_W-1:0]      x_out;
    logic [Y_W-1:0]      y_out;
    logic [COLOUR_W-1:0] colour_out;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        output start, dir, erase, colour,
        input  x_out, y_out, colour_out, plot, busy, done
    );

    modport slave (
        input  start, dir, erase, colour,
        output x_out, y_out, colour_out, plot, busy, done
    );
endinterface

// File: rtl/ui_arrow_drawer.sv
// Draws a fixed-size arrow (shaft plus two head diagonals) one pixel per step
// into a vga_adapter-style pixel port, with all outputs registered.
module ui_arrow_drawer #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOUR_W  = 3,
    parameter int SHAFT_LEN = 8,
    parameter int HEAD_LEN  = 4,
    parameter int ORIGIN_X  = 79,
    parameter int ORIGIN_Y  = 63,
    parameter int STEP_DIV  = 1
) (
    input logic               clk,
    input logic               reset,
    ui_arrow_drawer_if.slave  bus
);
    localparam int CNT_MAX = (SHAFT_LEN > HEAD_LEN) ? SHAFT_LEN : HEAD_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = $clog2(STEP_DIV + 1);

    localparam logic [CNT_W-1:0] SHAFT_CNT = CNT_W'(SHAFT_LEN);
    localparam logic [CNT_W-1:0] HEAD_CNT  = CNT_W'(HEAD_LEN);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [X_W-1:0]   OX        = X_W'(ORIGIN_X);
    localparam logic [Y_W-1:0]   OY        = Y_W'(ORIGIN_Y);
    localparam logic [X_W-1:0]   SX        = X_W'(SHAFT_LEN - 1);
    localparam logic [Y_W-1:0]   SY        = Y_W'(SHAFT_LEN - 1);

    typedef enum logic [2:0] {IDLE, SHAFT, HEAD_A, HEAD_B, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          dir_q, dir_d;
    logic [CNT_W-1:0]    seg_q, seg_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Direction vectors as modular deltas ('1 encodes -1) plus the arrow tip.
    logic [X_W-1:0] dx, px, tip_x;
    logic [Y_W-1:0] dy, py, tip_y;
    logic           step;

    always_comb begin
        dx    = '0;
        dy    = '0;
        px    = '0;
        py    = '0;
        tip_x = OX;
        tip_y = OY;
        case (dir_q)
            2'd0:    begin dy = '1;        px = X_W'(1); tip_y = OY - SY; end
            2'd1:    begin dy = Y_W'(1);   px = X_W'(1); tip_y = OY + SY; end
            2'd2:    begin dx = '1;        py = Y_W'(1); tip_x = OX - SX; end
            default: begin dx = X_W'(1);   py = Y_W'(1); tip_x = OX + SX; end
        endcase
    end

    assign step = (div_q == DIV_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        seg_d    = seg_q;
        div_d    = div_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dir_d    = bus.dir;
                    colour_d = bus.erase ? '0 : bus.colour;
                    x_d      = OX;
                    y_d      = OY;
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                    seg_d    = CNT_W'(1);
                    div_d    = '0;
                    state_d  = SHAFT;
                end
            end
            SHAFT: begin
                if (!step) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d  = '0;
                    plot_d = 1'b1;
                    if (seg_q == SHAFT_CNT) begin
                        x_d     = tip_x - dx + px;
                        y_d     = tip_y - dy + py;
                        seg_d   = CNT_W'(1);
                        state_d = HEAD_A;
                    end else begin
                        x_d   = x_q + dx;
                        y_d   = y_q + dy;
                        seg_d = seg_q + CNT_W'(1);
                    end
                end
            end
            HEAD_A: begin
                if (!step) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d  = '0;
                    plot_d = 1'b1;
                    if (seg_q == HEAD_CNT) begin
                        x_d     = tip_x - dx - px;
                        y_d     = tip_y - dy - py;
                        seg_d   = CNT_W'(1);
                        state_d = HEAD_B;
                    end else begin
                        x_d   = x_q - dx + px;
                        y_d   = y_q - dy + py;
                        seg_d = seg_q + CNT_W'(1);
                    end
                end
            end
            HEAD_B: begin
                // Completion is checked before pacing so done follows the last pixel directly.
                if (seg_q == HEAD_CNT) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    seg_d   = '0;
                    div_d   = '0;
                    state_d = DONE;
                end else if (!step) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d  = '0;
                    plot_d = 1'b1;
                    x_d    = x_q - dx - px;
                    y_d    = y_q - dy - py;
                    seg_d  = seg_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            dir_q    <= 2'd0;
            seg_q    <= '0;
            div_q    <= '0;
            x_q      <= OX;
            y_q      <= OY;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            seg_q    <= seg_d;
            div_q    <= div_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.x_out      = x_q;
    assign bus.y_out      = y_q;
    assign bus.colour_out = colour_q;
    assign bus.plot       = plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule
